// File: rtl/rvv_tb_outstanding_monitor.sv
// Outstanding-instruction monitor for an RVV bench: tracks issued-but-unretired
// LD/ST/ALU ops, idle/hang conditions, and latches counter and protocol errors.
module rvv_tb_outstanding_monitor #(
  parameter int unsigned ISSUE_NUM   = 2,
  parameter int unsigned RETIRE_NUM  = 4,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned HANG_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ISSUE_NUM-1:0]    issue_valid,
  input  logic [ISSUE_NUM-1:0]    issue_ready,
  input  logic [ISSUE_NUM*32-1:0] issue_inst,
  input  logic [RETIRE_NUM-1:0]   retire_valid,
  input  logic [RETIRE_NUM*2-1:0] retire_class,
  input  logic                    clr,
  output logic [CNT_W-1:0]        cnt_ld,
  output logic [CNT_W-1:0]        cnt_st,
  output logic [CNT_W-1:0]        cnt_alu,
  output logic [1:0]              state,
  output logic                    idle_stable,
  output logic                    hang,
  output logic                    err_ovf,
  output logic                    err_udf,
  output logic                    err_illegal
);

  localparam int unsigned SW     = CNT_W + 2;
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned HANG_W = $clog2(HANG_CYCLES + 1);
  localparam int unsigned NCLS   = 3;
  localparam int unsigned C_LD   = 0;
  localparam int unsigned C_ST   = 1;
  localparam int unsigned C_ALU  = 2;

  localparam logic [6:0] OP_LD = 7'b0000111;
  localparam logic [6:0] OP_ST = 7'b0100111;
  localparam logic [6:0] OP_V  = 7'b1010111;
  localparam logic signed [SW-1:0] CNT_MAX = $signed({2'b00, {CNT_W{1'b1}}});

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_UNKNOW = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q [NCLS];
  logic [CNT_W-1:0]       cnt_d [NCLS];
  logic signed [SW-1:0]   iss   [NCLS];
  logic signed [SW-1:0]   ret   [NCLS];
  logic signed [SW-1:0]   nxt   [NCLS];
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [HANG_W-1:0]      hang_cnt_q, hang_cnt_d;
  logic                   idle_stable_q, idle_stable_d;
  logic                   hang_q, hang_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   ill_q, ill_d;

  // Only opcode and funct3 of each instruction are inspected.
  logic unused_inst_bits;
  assign unused_inst_bits = ^issue_inst;

  // Next-state: per-class net change, saturation, sticky errors, idle/hang tracking.
  always_comb begin
    for (int unsigned c = 0; c < NCLS; c++) begin
      iss[c]   = '0;
      ret[c]   = '0;
      nxt[c]   = '0;
      cnt_d[c] = cnt_q[c];
    end
    state_d       = state_q;
    idle_d        = idle_q;
    hang_cnt_d    = hang_cnt_q;
    idle_stable_d = idle_stable_q;
    hang_d        = hang_q;
    ovf_d         = ovf_q;
    udf_d         = udf_q;
    ill_d         = ill_q;

    for (int unsigned i = 0; i < ISSUE_NUM; i++) begin
      if (issue_valid[i] && issue_ready[i]) begin
        case (issue_inst[i*32 +: 7])
          OP_LD:   iss[C_LD] = iss[C_LD] + SW'(1);
          OP_ST:   iss[C_ST] = iss[C_ST] + SW'(1);
          OP_V: begin
            // funct3 == 111 is a vector config op: neither counted nor an error.
            if (issue_inst[i*32+12 +: 3] != 3'b111) iss[C_ALU] = iss[C_ALU] + SW'(1);
          end
          default: ill_d = 1'b1;
        endcase
      end
    end

    for (int unsigned j = 0; j < RETIRE_NUM; j++) begin
      if (retire_valid[j]) begin
        case (retire_class[j*2 +: 2])
          2'b00:   ret[C_LD]  = ret[C_LD]  + SW'(1);
          2'b01:   ret[C_ST]  = ret[C_ST]  + SW'(1);
          2'b10:   ret[C_ALU] = ret[C_ALU] + SW'(1);
          default: ill_d = 1'b1;
        endcase
      end
    end

    for (int unsigned c = 0; c < NCLS; c++) begin
      nxt[c] = $signed({2'b00, cnt_q[c]}) + iss[c] - ret[c];
      if (nxt[c][SW-1]) begin
        cnt_d[c] = '0;
        udf_d    = 1'b1;
      end else if (nxt[c] > CNT_MAX) begin
        cnt_d[c] = '1;
        ovf_d    = 1'b1;
      end else begin
        cnt_d[c] = nxt[c][CNT_W-1:0];
      end
    end

    if (state_q == ST_IDLE && !(|issue_valid)) begin
      if (idle_q != IDLE_W'(IDLE_CYCLES)) idle_d = idle_q + IDLE_W'(1);
    end else begin
      idle_d = '0;
    end
    idle_stable_d = (idle_d == IDLE_W'(IDLE_CYCLES));

    if (state_q == ST_BUSY && !(|retire_valid)) begin
      if (hang_cnt_q != HANG_W'(HANG_CYCLES)) hang_cnt_d = hang_cnt_q + HANG_W'(1);
    end else begin
      hang_cnt_d = '0;
    end
    hang_d = hang_q | (hang_cnt_d == HANG_W'(HANG_CYCLES));

    if (ovf_d || udf_d || ill_d) begin
      state_d = ST_UNKNOW;
    end else if ((cnt_d[C_LD] != '0) || (cnt_d[C_ST] != '0) || (cnt_d[C_ALU] != '0)) begin
      state_d = ST_BUSY;
    end else begin
      state_d = ST_IDLE;
    end

    // Clear wins over any same-cycle traffic.
    if (clr) begin
      for (int unsigned c = 0; c < NCLS; c++) cnt_d[c] = '0;
      state_d       = ST_IDLE;
      idle_d        = '0;
      hang_cnt_d    = '0;
      idle_stable_d = 1'b0;
      hang_d        = 1'b0;
      ovf_d         = 1'b0;
      udf_d         = 1'b0;
      ill_d         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCLS; c++) cnt_q[c] <= '0;
      state_q       <= ST_UNKNOW;
      idle_q        <= '0;
      hang_cnt_q    <= '0;
      idle_stable_q <= 1'b0;
      hang_q        <= 1'b0;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
      ill_q         <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCLS; c++) cnt_q[c] <= cnt_d[c];
      state_q       <= state_d;
      idle_q        <= idle_d;
      hang_cnt_q    <= hang_cnt_d;
      idle_stable_q <= idle_stable_d;
      hang_q        <= hang_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
      ill_q         <= ill_d;
    end
  end

  assign cnt_ld      = cnt_q[C_LD];
  assign cnt_st      = cnt_q[C_ST];
  assign cnt_alu     = cnt_q[C_ALU];
  assign state       = state_q;
  assign idle_stable = idle_stable_q;
  assign hang        = hang_q;
  assign err_ovf     = ovf_q;
  assign err_udf     = udf_q;
  assign err_illegal = ill_q;

endmodule

// File: tb/tb_rvv_tb_outstanding_monitor.sv
// Bench for rvv_tb_outstanding_monitor: directed scenarios then random traffic,
// every cycle compared against an integer-arithmetic reference model.
module tb_rvv_tb_outstanding_monitor;

  localparam int IDLE_N = 16;
  localparam int HANG_N = 1024;
  localparam int CMAX   = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  issue_valid, issue_ready;
  logic [63:0] issue_inst;
  logic [3:0]  retire_valid;
  logic [7:0]  retire_class;
  logic        clr;
  logic [5:0]  cnt_ld, cnt_st, cnt_alu;
  logic [1:0]  state;
  logic        idle_stable, hang, err_ovf, err_udf, err_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_cnt [3];
  int m_state, m_idle, m_hang_cnt;
  bit m_idle_st, m_hang, m_ovf, m_udf, m_ill;

  rvv_tb_outstanding_monitor dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
    .retire_valid(retire_valid), .retire_class(retire_class), .clr(clr),
    .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_alu(cnt_alu), .state(state),
    .idle_stable(idle_stable), .hang(hang),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {cnt_ld, cnt_st, cnt_alu, state, idle_stable, hang, err_ovf, err_udf, err_illegal};

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;
    m_state = 2; m_idle = 0; m_hang_cnt = 0;
    m_idle_st = 0; m_hang = 0; m_ovf = 0; m_udf = 0; m_ill = 0;
  endfunction

  function automatic logic [24:0] model_vec();
    return {6'(m_cnt[0]), 6'(m_cnt[1]), 6'(m_cnt[2]), 2'(m_state),
            m_idle_st, m_hang, m_ovf, m_udf, m_ill};
  endfunction

  // One clock of the rules, applied to the inputs currently driven.
  function automatic void model_step();
    int iss [3];
    int ret [3];
    int n;
    logic [31:0] ins;
    logic [1:0]  cls;
    if (clr) begin
      model_reset();
      m_state = 0;
      return;
    end
    for (int c = 0; c < 3; c++) begin iss[c] = 0; ret[c] = 0; end
    if (m_state == 0 && issue_valid == 2'b00) m_idle = (m_idle < IDLE_N) ? m_idle + 1 : m_idle;
    else m_idle = 0;
    m_idle_st = (m_idle == IDLE_N);
    if (m_state == 1 && retire_valid == 4'b0000) m_hang_cnt = (m_hang_cnt < HANG_N) ? m_hang_cnt + 1 : m_hang_cnt;
    else m_hang_cnt = 0;
    if (m_hang_cnt == HANG_N) m_hang = 1;
    for (int p = 0; p < 2; p++) begin
      if (issue_valid[p] && issue_ready[p]) begin
        ins = issue_inst[p*32 +: 32];
        if (ins[6:0] == 7'h07) iss[0]++;
        else if (ins[6:0] == 7'h27) iss[1]++;
        else if (ins[6:0] == 7'h57) begin
          if (ins[14:12] != 3'd7) iss[2]++;
        end else m_ill = 1;
      end
    end
    for (int q = 0; q < 4; q++) begin
      if (retire_valid[q]) begin
        cls = retire_class[q*2 +: 2];
        if (cls == 2'd3) m_ill = 1;
        else ret[cls]++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      n = m_cnt[c] + iss[c] - ret[c];
      if (n > CMAX) begin n = CMAX; m_ovf = 1; end
      if (n < 0) begin n = 0; m_udf = 1; end
      m_cnt[c] = n;
    end
    if (m_ovf || m_udf || m_ill) m_state = 2;
    else if (m_cnt[0] + m_cnt[1] + m_cnt[2] > 0) m_state = 1;
    else m_state = 0;
  endfunction

  task automatic check_vec(input string tag);
    logic [24:0] exp_v;
    exp_v = model_vec();
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_val(input string tag, input int obs_v, input int exp_v);
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_vec(tag);
  endtask

  task automatic quiet();
    issue_valid = '0; issue_ready = '0; issue_inst = '0;
    retire_valid = '0; retire_class = '0; clr = 1'b0;
  endtask

  task automatic do_issue(input int p, input logic [31:0] ins);
    issue_valid[p] = 1'b1;
    issue_ready[p] = 1'b1;
    issue_inst[p*32 +: 32] = ins;
  endtask

  task automatic do_retire(input int q, input logic [1:0] cls);
    retire_valid[q] = 1'b1;
    retire_class[q*2 +: 2] = cls;
  endtask

  task automatic do_clr();
    quiet();
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] ins;
    int r;
    ins = $urandom;
    r = $urandom_range(0, 99);
    if (r < 30) ins[6:0] = 7'h07;
    else if (r < 60) ins[6:0] = 7'h27;
    else if (r < 88) begin ins[6:0] = 7'h57; ins[14:12] = 3'($urandom_range(0, 6)); end
    else if (r < 99) begin ins[6:0] = 7'h57; ins[14:12] = 3'd7; end
    else ins[6:0] = 7'h33;
    return ins;
  endfunction

  initial begin
    quiet();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset");
    expect_val("reset_state", int'(state), 2);

    // Release reset away from the edge; first edge leaves UNKNOW.
    rst_n = 1'b1;
    tick("rel");
    expect_val("rel_state_idle", int'(state), 0);
    for (int k = 0; k < 15; k++) tick("idle_wait");
    expect_val("idle_stable_early", int'(idle_stable), 0);
    tick("idle_wait");
    expect_val("idle_stable_16", int'(idle_stable), 1);

    // Two LD in one cycle, one LD retire the next.
    do_issue(0, 32'h0000_0007); do_issue(1, 32'h0000_0007);
    tick("ld2");
    expect_val("ld2_cnt", int'(cnt_ld), 2);
    expect_val("ld2_state", int'(state), 1);
    expect_val("ld2_idle_stable", int'(idle_stable), 0);
    quiet(); do_retire(0, 2'b00);
    tick("ld_ret");
    expect_val("ld_ret_cnt", int'(cnt_ld), 1);
    expect_val("ld_ret_state", int'(state), 1);
    quiet(); do_retire(3, 2'b00);
    tick("ld_drain");
    expect_val("ld_drain_state", int'(state), 0);

    // ALU issue and retire in the same cycle cancel out.
    quiet(); do_issue(0, 32'h0000_0057); do_issue(1, 32'h1234_5057);
    tick("alu2");
    quiet(); do_issue(1, 32'h0000_6057);
    tick("alu3");
    expect_val("alu3_cnt", int'(cnt_alu), 3);
    quiet(); do_issue(0, 32'h0000_2057); do_retire(2, 2'b10);
    tick("alu_bal");
    expect_val("alu_bal_cnt", int'(cnt_alu), 3);
    expect_val("alu_bal_err", int'({err_ovf, err_udf, err_illegal}), 0);
    quiet(); do_issue(0, 32'h0000_7057);
    tick("opcfg");
    expect_val("opcfg_cnt", int'(cnt_alu), 3);
    expect_val("opcfg_err", int'(err_illegal), 0);
    quiet(); do_retire(0, 2'b10); do_retire(1, 2'b10); do_retire(2, 2'b10);
    tick("alu_drain");
    expect_val("alu_drain_cnt", int'(cnt_alu), 0);

    // Fill ST to the ceiling, then overflow it.
    for (int k = 0; k < 31; k++) begin
      quiet(); do_issue(0, 32'h0000_0027); do_issue(1, 32'h0000_0027);
      tick("st_fill");
    end
    quiet(); do_issue(0, 32'h0000_0027);
    tick("st_fill");
    expect_val("st_full", int'(cnt_st), 63);
    expect_val("st_full_ovf", int'(err_ovf), 0);
    quiet(); do_issue(0, 32'h0000_0027); do_issue(1, 32'h0000_0027);
    tick("st_ovf");
    expect_val("st_ovf_cnt", int'(cnt_st), 63);
    expect_val("st_ovf_flag", int'(err_ovf), 1);
    expect_val("st_ovf_state", int'(state), 2);
    quiet(); do_issue(0, 32'h0000_0027); clr = 1'b1;
    tick("clr_drop");
    expect_val("clr_vec", int'(obs), 0);

    // Underflow on LD, then an illegal opcode.
    quiet(); do_retire(1, 2'b00);
    tick("udf");
    expect_val("udf_cnt", int'(cnt_ld), 0);
    expect_val("udf_flag", int'(err_udf), 1);
    quiet(); do_issue(1, 32'h0000_707F);
    tick("illegal");
    expect_val("illegal_flag", int'(err_illegal), 1);
    do_clr();
    quiet(); do_retire(2, 2'b11);
    tick("ret_cls3");
    expect_val("ret_cls3_flag", int'(err_illegal), 1);
    do_clr();

    // Hang: one ALU outstanding with no retire.
    quiet(); do_issue(0, 32'h0000_0057);
    tick("hang_issue");
    quiet();
    for (int k = 0; k < HANG_N - 1; k++) tick("hang_wait");
    expect_val("hang_early", int'(hang), 0);
    tick("hang_wait");
    expect_val("hang_set", int'(hang), 1);
    do_retire(0, 2'b10);
    tick("hang_ret");
    expect_val("hang_sticky", int'(hang), 1);
    expect_val("hang_ret_cnt", int'(cnt_alu), 0);
    do_clr();
    expect_val("hang_clr", int'(hang), 0);

    // Asynchronous reset in the middle of traffic.
    quiet(); do_issue(0, 32'h0000_0007); do_issue(1, 32'h0000_0027);
    tick("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_vec("async_rst");
    expect_val("async_rst_cnt", int'(cnt_ld), 0);
    #1 rst_n = 1'b1;
    quiet(); do_issue(0, 32'h0000_0007);
    tick("post_rst");
    expect_val("post_rst_state", int'(state), 1);
    do_clr();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      quiet();
      clr = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++) begin
        issue_valid[p] = 1'($urandom_range(0, 1));
        issue_ready[p] = ($urandom_range(0, 9) < 7);
        issue_inst[p*32 +: 32] = rand_inst();
      end
      for (int q = 0; q < 4; q++) begin
        retire_valid[q] = ($urandom_range(0, 99) < 15);
        retire_class[q*2 +: 2] = ($urandom_range(0, 99) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
